// File: rtl/mbscore_wb_ctrl.sv
// Purpose : writeback controller; sequences one execute-stage request through
//           memory access, register-file write and retire.
// Latency : op0 accept->done 1 cycle, op1 2 cycles, op2 ack+1, op3 ack+2.
// Backpressure: req_ready is high only in IDLE; mem_req holds until mem_ack.
// Ports   : clk/rst_n (async active-low); req_valid/req_ready/req_op/req_rd/req_alu
//           request in; mem_req/mem_we/mem_wdata/mem_ack/mem_rdata memory side;
//           wb_sel, rf_we/rf_waddr/rf_wdata, jump, done, timeout_err results.
// Options : define MBSCORE_WB_TIMEOUT_EN to abandon a memory access after 255
//           cycles without mem_ack (sets sticky timeout_err, retires, no rf write).

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mbscore_wb_ctrl #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [RD_WIDTH-1:0]   req_rd,
    input  logic [DATA_WIDTH-1:0] req_alu,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            wb_sel,
    output logic                  rf_we,
    output logic [RD_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  jump,
    output logic                  done,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        REG_WR   = 2'd2,
        RETIRE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_BRANCH = 2'd0;
    localparam logic [1:0] OP_ALU_RF = 2'd1;
    localparam logic [1:0] OP_STORE  = 2'd2;
    localparam logic [1:0] OP_LOAD   = 2'd3;

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [RD_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0] data_q;   // ALU result, replaced by load data on ack
    logic                  accept;
    logic                  tmo_fire;

    // Reset forces ready high even though the state register already reads IDLE,
    // so the handshake is defined while rst_n is still low.
    assign req_ready = (state_q == IDLE) || !rst_n;
    assign accept    = req_valid && (state_q == IDLE);

`ifdef MBSCORE_WB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       tmo_err_q;

    // Counter reads n-1 in the n-th MEM_WAIT cycle; firing at 254 gives exactly
    // 255 cycles of mem_req before the access is abandoned.
    assign tmo_fire = (state_q == MEM_WAIT) && !mem_ack && (tmo_cnt_q == 8'd254);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == MEM_WAIT) ? tmo_cnt_q + 8'd1 : 8'd0;
            if (tmo_fire) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_BRANCH: state_d = RETIRE;
                        OP_ALU_RF: state_d = REG_WR;
                        default:   state_d = MEM_WAIT;
                    endcase
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = (op_q == OP_LOAD) ? REG_WR : RETIRE;
                end else if (tmo_fire) begin
                    state_d = RETIRE;
                end
            end
            REG_WR:  state_d = RETIRE;
            RETIRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 2'd0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= req_op;
            rd_q   <= req_rd;
            data_q <= req_alu;
        end else if ((state_q == MEM_WAIT) && mem_ack && (op_q == OP_LOAD)) begin
            data_q <= mem_rdata;
        end
    end

    // Outputs are decoded from registered state only, so they are glitch-free
    // and drop to zero the instant the async reset lands.
    assign mem_req   = (state_q == MEM_WAIT);
    assign mem_we    = mem_req && (op_q == OP_STORE);
    assign mem_wdata = mem_we ? data_q : '0;
    assign rf_we     = (state_q == REG_WR) && (rd_q != '0);
    assign rf_waddr  = (state_q == REG_WR) ? rd_q : '0;
    assign rf_wdata  = (state_q == REG_WR) ? data_q : '0;
    assign jump      = (state_q == RETIRE) && (op_q == OP_BRANCH) && data_q[0];
    assign done      = (state_q == RETIRE);
    assign wb_sel    = (state_q == IDLE) ? 2'd0 : op_q;

endmodule

// File: tb/tb_mbscore_wb_ctrl.sv
module tb_mbscore_wb_ctrl;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [RW-1:0] req_rd = '0;
    logic [DW-1:0] req_alu = '0;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    wb_sel;
    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          jump;
    logic          done;
    logic          timeout_err;

    mbscore_wb_ctrl #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_alu     (req_alu),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_sel      (wb_sel),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .jump        (jump),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } rf_exp_t;

    rf_exp_t rf_q[$];     // expected register-file writes, in order
    logic    done_q[$];   // expected jump value for each retire, in order

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [RW-1:0] rd, input logic [DW-1:0] alu);
        chk("req_ready_before_send", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_alu   = alu;
        tick();
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_rd    = '0;
        req_alu   = '0;
    endtask

    // Scoreboard monitor: every rf write and every retire must match the next
    // expected entry; pulses must never last two cycles.
    logic prev_rf_we = 1'b0;
    logic prev_done  = 1'b0;
    always @(negedge clk) begin
        rf_exp_t e;
        logic    ej;
        if (rf_we) begin
            chk("rf_we_one_cycle", prev_rf_we, 0);
            if (rf_q.size() == 0) begin
                chk("rf_we_unexpected", rf_we, 0);
            end else begin
                e = rf_q.pop_front();
                chk("rf_waddr", rf_waddr, e.rd);
                chk("rf_wdata", rf_wdata, e.data);
            end
        end
        if (done) begin
            chk("done_one_cycle", prev_done, 0);
            if (done_q.size() == 0) begin
                chk("done_unexpected", done, 0);
            end else begin
                ej = done_q.pop_front();
                chk("jump_at_retire", jump, ej);
            end
        end else if (jump) begin
            chk("jump_without_done", jump, 0);
        end
        prev_rf_we = rf_we;
        prev_done  = done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_wb_sel", wb_sel, 0);
        chk("rst_timeout_err", timeout_err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Op1 rd=7 alu=0x1234: rf write next cycle, done the one after
        rf_q.push_back('{rd: 5'd7, data: 32'h0000_1234});
        done_q.push_back(1'b0);
        send(2'd1, 5'd7, 32'h0000_1234);
        chk("op1_rf_we", rf_we, 1);
        chk("op1_wb_sel", wb_sel, 1);
        chk("op1_req_ready_busy", req_ready, 0);
        tick();
        chk("op1_done", done, 1);
        chk("op1_rf_we_after", rf_we, 0);
        tick();
        chk("op1_idle_wb_sel", wb_sel, 0);

        // Op3 rd=3, ack on the 4th MEM_WAIT cycle; stray req_valid ignored
        rf_q.push_back('{rd: 5'd3, data: 32'hDEAD_BEEF});
        done_q.push_back(1'b0);
        send(2'd3, 5'd3, 32'h0000_0055);
        for (int k = 1; k <= 4; k++) begin
            chk("op3_mem_req", mem_req, 1);
            chk("op3_mem_we", mem_we, 0);
            chk("op3_wb_sel", wb_sel, 3);
            if (k == 1) begin
                req_valid = 1'b1;
                req_op    = 2'd1;
                req_rd    = 5'd9;
                req_alu   = 32'h99;
            end
            if (k == 4) begin
                req_valid = 1'b0;
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("op3_mem_req_dropped", mem_req, 0);
        chk("op3_rf_we", rf_we, 1);
        tick();
        chk("op3_done", done, 1);
        tick();

        // Op2 store, ack after 2 cycles, stable store data, no rf write
        done_q.push_back(1'b0);
        send(2'd2, 5'd5, 32'hA5A5_A5A5);
        for (int k = 1; k <= 2; k++) begin
            chk("op2_mem_req", mem_req, 1);
            chk("op2_mem_we", mem_we, 1);
            chk("op2_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
            if (k == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk("op2_mem_req_dropped", mem_req, 0);
        chk("op2_done", done, 1);
        tick();

        // Stray mem_ack while idle
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_ready", req_ready, 1);
        chk("stray_ack_mem_req", mem_req, 0);

        // Op0 alu=1 then op1 rd=0 held back-to-back
        done_q.push_back(1'b1);
        done_q.push_back(1'b0);
        send(2'd0, 5'd2, 32'h0000_0001);
        chk("op0_jump", jump, 1);
        chk("op0_done", done, 1);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_rd    = 5'd0;
        req_alu   = 32'hFF;
        chk("b2b_ready_in_retire", req_ready, 0);
        tick();
        chk("b2b_ready_after_retire", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("b2b_rd0_rf_we", rf_we, 0);
        chk("b2b_wb_sel", wb_sel, 1);
        tick();
        chk("b2b_done", done, 1);
        tick();

`ifdef MBSCORE_WB_TIMEOUT_EN
        // Op3 with no ack: gives up after 255 cycles
        begin
            int cyc;
            cyc = 0;
            done_q.push_back(1'b0);
            send(2'd3, 5'd4, 32'h0);
            while (mem_req && cyc < 400) begin
                cyc++;
                tick();
            end
            chk("tmo_mem_req_cycles", cyc, 255);
            chk("tmo_done", done, 1);
            chk("tmo_err_set", timeout_err, 1);
            tick();
            tick();
            chk("tmo_err_sticky", timeout_err, 1);
        end
`else
        // Without the timeout option a load waits as long as it takes
        rf_q.push_back('{rd: 5'd4, data: 32'h0BAD_F00D});
        done_q.push_back(1'b0);
        send(2'd3, 5'd4, 32'h0);
        repeat (300) tick();
        chk("long_wait_mem_req", mem_req, 1);
        chk("long_wait_timeout_err", timeout_err, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("long_wait_rf_we", rf_we, 1);
        tick();
        tick();
`endif

        // Reset during MEM_WAIT discards the request
        send(2'd3, 5'd6, 32'h77);
        tick();
        chk("rstw_mem_req_before", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_mem_req", mem_req, 0);
        chk("rstw_req_ready", req_ready, 1);
        chk("rstw_wb_sel", wb_sel, 0);
        chk("rstw_timeout_err", timeout_err, 0);
        tick();
        chk("rstw_no_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstw_ready_after", req_ready, 1);
        chk("rstw_no_done_after", done, 0);
        tick();

        chk("rf_q_drained", rf_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mbscore_wb_ctrl.md
MBSCORE_WB_CTRL -- requirements
Module: mbscore_wb_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default `DATA_WIDTH (32), datapath width.
REQ-002 Parameter: RD_WIDTH, default 5, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  execute stage presents a writeback request.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_op  input  2  0=branch/jump, 1=ALU->reg, 2=ALU->mem, 3=mem->reg.
REQ-008 req_rd  input  RD_WIDTH  destination register.
REQ-009 req_alu  input  DATA_WIDTH  ALU result.
REQ-010 mem_req  output  1  memory access request, held until acknowledged.
REQ-011 mem_we  output  1  1=store, 0=load; valid while mem_req=1.
REQ-012 mem_wdata  output  DATA_WIDTH  store data.
REQ-013 mem_ack  input  1  memory completes the access this cycle.
REQ-014 mem_rdata  input  DATA_WIDTH  load data; valid when mem_ack=1.
REQ-015 wb_sel  output  2  registered copy of the op in flight, drives the WB mux select.
REQ-016 rf_we  output  1  register-file write enable, one-cycle pulse.
REQ-017 rf_waddr  output  RD_WIDTH  register-file write address.
REQ-018 rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-019 jump  output  1  one-cycle pulse carrying req_alu[0] of a branch op.
REQ-020 done  output  1  one-cycle pulse when a request retires.
REQ-021 timeout_err  output  1  sticky memory-timeout flag (see Configuration).

Function
REQ-022 FSM states SHALL be IDLE, MEM_WAIT, REG_WR, RETIRE; req_ready SHALL be 1 only in IDLE.
REQ-023 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; req_op, req_rd and req_alu are latched at that edge.
REQ-024 Op 0: IDLE->RETIRE; in RETIRE, jump=latched alu[0] and done=1 for one cycle; no rf or mem activity.
REQ-025 Op 1: IDLE->REG_WR; in REG_WR, rf_we=1, rf_waddr=rd, rf_wdata=alu; REG_WR->RETIRE; done pulses in RETIRE (latency 2 cycles accept->done).
REQ-026 Op 2: IDLE->MEM_WAIT with mem_req=1, mem_we=1, mem_wdata=alu; on mem_ack MEM_WAIT->RETIRE.
REQ-027 Op 3: IDLE->MEM_WAIT with mem_req=1, mem_we=0; on mem_ack, mem_rdata is captured into rf_wdata and FSM goes to REG_WR, then RETIRE.
REQ-028 mem_req, mem_we, mem_wdata SHALL stay stable from MEM_WAIT entry until the mem_ack cycle; mem_req SHALL be 0 the cycle after mem_ack.
REQ-029 rf_we SHALL be suppressed when rd=0; the request still retires with done.
REQ-030 RETIRE->IDLE unconditionally; a back-to-back request is accepted the cycle after RETIRE.
REQ-031 mem_ack while not in MEM_WAIT SHALL be ignored; req_valid while req_ready=0 SHALL be ignored and not latched.
REQ-032 wb_sel SHALL equal the latched op from acceptance until RETIRE, and 0 in IDLE.
REQ-033 rf_we, jump, done SHALL never be high for more than one consecutive cycle per request.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE and all outputs to 0 except req_ready=1 (rst_n=0 forces req_ready=1 regardless of state).
REQ-035 Reset during MEM_WAIT SHALL drop mem_req the same instant; the in-flight request is discarded without done.
REQ-036 timeout_err SHALL be cleared only by reset.

Configuration
REQ-037 Macro MBSCORE_WB_TIMEOUT_EN: when defined, an 8-bit counter runs in MEM_WAIT; after 255 cycles without mem_ack, mem_req drops, timeout_err sets, FSM goes to RETIRE (done pulses, no rf write).
REQ-038 Without MBSCORE_WB_TIMEOUT_EN, MEM_WAIT waits indefinitely and timeout_err is tied to 0.

Verification
REQ-039 Op1, rd=7, alu=0x1234 -> rf_we=1 with waddr=7, wdata=0x1234 one cycle after accept; done the next cycle.
REQ-040 Op3, rd=3, mem_ack 4 cycles after accept with rdata=0xDEADBEEF -> mem_req high 4 cycles, mem_we=0, then rf_we with wdata=0xDEADBEEF, then done.
REQ-041 Op2, alu=0xA5A5A5A5, ack after 2 cycles -> mem_we=1, wdata stable for 2 cycles, no rf_we, done after ack.
REQ-042 Op0 alu=1 then op1 rd=0 back-to-back -> jump=1 pulse, second request accepted after RETIRE, rf_we stays 0, two done pulses.
REQ-043 Op3, rst_n low during MEM_WAIT -> mem_req 0 immediately, no done, req_ready=1 after reset.
REQ-044 With MBSCORE_WB_TIMEOUT_EN, op3 and no ack -> mem_req drops after 255 cycles, timeout_err=1 sticky, done pulses, rf_we stays 0.
